program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256: maximum program length in 32-bit words (1..256).
REQ-002 Parameter ADDR_STEP, default 4: byte increment between consecutive instruction addresses.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  upstream program word is present.
REQ-006 in_word  in  32  program word (instruction encoding).
REQ-007 in_last  in  1  qualifies in_word as final word of program.
REQ-008 in_ready  out  1  loader accepts a word this cycle.
REQ-009 instr_addr  out  32  instruction-memory byte address during load.
REQ-010 instr_in  out  32  instruction-memory write data.
REQ-011 instr_write  out  1  instruction-memory write enable.
REQ-012 instr_read  out  1  instruction-memory read enable.
REQ-013 initializing  out  1  high while the loader owns the instruction-memory address.
REQ-014 pc_reset  out  1  holds the PC register at 0.
REQ-015 pc_write  out  1  enables the PC to update.
REQ-016 word_count  out  9  number of words written so far.
REQ-017 cycle_no  out  16  processor cycles elapsed in RUN.
REQ-018 done  out  1  program loaded; processor running.
REQ-019 error  out  1  overflow detected.
REQ-020 checksum  out  32  additive checksum of loaded words.

Function
REQ-021 The states SHALL be LOAD, START, RUN and ERROR.
REQ-022 In LOAD: in_ready=1, initializing=1, pc_reset=1, pc_write=0, instr_read=0.
REQ-023 In LOAD, instr_write SHALL equal in_valid, combinationally; instr_addr=word_count*ADDR_STEP; instr_in=in_word; zero-latency write on the accepting edge.
REQ-024 Each accepted word (in_valid&in_ready) SHALL increment word_count by 1 on that edge.
REQ-025 An accepted word with in_last=1 SHALL move the state LOAD->START; otherwise the state stays LOAD.
REQ-026 A word presented while word_count==MAX_WORDS SHALL NOT be written (instr_write=0); the state SHALL move to ERROR and word_count SHALL hold.
REQ-027 START SHALL last exactly one cycle: initializing=0, instr_read=1, pc_reset=1, pc_write=0, in_ready=0; then the state SHALL move to RUN.
REQ-028 In RUN: initializing=0, instr_read=1, pc_reset=0, pc_write=1, done=1, in_ready=0; cycle_no SHALL increment every cycle and wrap from 0xFFFF to 0.
REQ-029 In ERROR: error=1, in_ready=0, instr_write=0, pc_reset=1, pc_write=0, initializing=1; the state SHALL leave ERROR only through reset.
REQ-030 instr_addr SHALL be 0 and instr_write SHALL be 0 outside LOAD.
REQ-031 in_valid while in_ready=0 SHALL be ignored; no state change.

Reset
REQ-032 reset=1 at any edge, including mid-load or in RUN, SHALL force state=LOAD, word_count=0, cycle_no=0 and checksum=0; reset dominates simultaneous in_valid.
REQ-033 Words already written before reset SHALL NOT be cleared in memory; reloading SHALL overwrite them from address 0.

Configuration
REQ-034 With LOADER_CHECKSUM_EN defined, checksum SHALL add each written in_word modulo 2^32 on its accepting edge and hold in START/RUN/ERROR.
REQ-035 Without LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator SHALL be present.

Structure
REQ-036 The state encoding (LOAD=0, START=1, RUN=2, ERROR=3) and the default-ADDR_STEP constant SHALL live in the shared mips_pkg package.
REQ-037 The block SHALL be a single flat module; no sub-module is required.

Verification
REQ-038 Load 7 words 0x20110005,0x20100002,0x2012fffd,0xac000005,0x00009820,0x00119842,0x02304822 (last on 7th) -> writes at addresses 0..24 in steps of 4, word_count=7, one START cycle, then done=1, pc_reset=0.
REQ-039 Single word with in_last=1 -> write at address 0, START at the next cycle, RUN at the following cycle.
REQ-040 MAX_WORDS=4, present 5 words with no in_last -> 4 writes, 5th not written, error=1, word_count=4.
REQ-041 Reset asserted after 3 words, then reload 2 words -> second load writes addresses 0 and 4, word_count=2.
REQ-042 In RUN for 65537 cycles -> cycle_no wraps to 1; in_valid pulses ignored, in_ready=0.
REQ-043 With LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001; without the macro -> checksum=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the program loader: state encoding, default address step
// and the word-index to byte-address helper.
package mips_pkg;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StError = 2'd3
    } loader_state_e;

    localparam int unsigned DefaultAddrStep = 4;

    function automatic logic [31:0] word_addr(input logic [8:0] count, input int unsigned step);
        return 32'(count) * step;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams a program into instruction memory, then releases the PC and counts run cycles.
// Optional feature: define LOADER_CHECKSUM_EN to accumulate an additive checksum of loaded words.
module program_loader
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned ADDR_STEP = DefaultAddrStep
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] instr_addr,
    output logic [31:0] instr_in,
    output logic        instr_write,
    output logic        instr_read,
    output logic        initializing,
    output logic        pc_reset,
    output logic        pc_write,
    output logic [8:0]  word_count,
    output logic [15:0] cycle_no,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum
);

    localparam logic [8:0] MaxCount = 9'(MAX_WORDS);

    loader_state_e state;
    logic          in_load;
    logic          full;
    logic          accept;

    assign in_load = (state == StLoad);
    assign full    = (word_count == MaxCount);
    // A word offered once the memory is full is refused and sends the loader to ERROR.
    assign accept  = in_load && in_valid && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StLoad;
            word_count <= '0;
            cycle_no   <= '0;
        end else begin
            case (state)
                StLoad: begin
                    if (in_valid) begin
                        if (full) begin
                            state <= StError;
                        end else begin
                            word_count <= word_count + 9'd1;
                            if (in_last) state <= StStart;
                        end
                    end
                end
                StStart: state <= StRun;
                StRun:   cycle_no <= cycle_no + 16'd1;
                default: state <= StError;
            endcase
        end
    end

    // Control outputs decode the registered state only.
    always_comb begin
        in_ready     = 1'b0;
        initializing = 1'b0;
        pc_reset     = 1'b0;
        pc_write     = 1'b0;
        instr_read   = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (state)
            StLoad: begin
                in_ready     = 1'b1;
                initializing = 1'b1;
                pc_reset     = 1'b1;
            end
            StStart: begin
                instr_read = 1'b1;
                pc_reset   = 1'b1;
            end
            StRun: begin
                instr_read = 1'b1;
                pc_write   = 1'b1;
                done       = 1'b1;
            end
            default: begin
                error        = 1'b1;
                initializing = 1'b1;
                pc_reset     = 1'b1;
            end
        endcase
    end

    assign instr_write = accept;
    assign instr_addr  = in_load ? word_addr(word_count, ADDR_STEP) : 32'd0;
    assign instr_in    = in_load ? in_word : 32'd0;

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + in_word;
        end
    end
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: constant-expectation table, directed corner
// sequences and randomized traffic against a behavioural model of the loader.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = '0;
    logic        in_last = 1'b0;

    logic        in_ready, instr_write, instr_read, initializing, pc_reset, pc_write, done, error;
    logic [31:0] instr_addr, instr_in, checksum;
    logic [8:0]  word_count;
    logic [15:0] cycle_no;

    logic        s_ready, s_write, s_read, s_init, s_pc_reset, s_pc_write, s_done, s_error;
    logic [31:0] s_addr, s_in, s_checksum;
    logic [8:0]  s_count;
    logic [15:0] s_cycle;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .in_ready(in_ready), .instr_addr(instr_addr), .instr_in(instr_in),
        .instr_write(instr_write), .instr_read(instr_read), .initializing(initializing),
        .pc_reset(pc_reset), .pc_write(pc_write), .word_count(word_count),
        .cycle_no(cycle_no), .done(done), .error(error), .checksum(checksum)
    );

    program_loader #(.MAX_WORDS(4)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .in_ready(s_ready), .instr_addr(s_addr), .instr_in(s_in),
        .instr_write(s_write), .instr_read(s_read), .initializing(s_init),
        .pc_reset(s_pc_reset), .pc_write(s_pc_write), .word_count(s_count),
        .cycle_no(s_cycle), .done(s_done), .error(s_error), .checksum(s_checksum)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model of the default-size loader (256 words, step 4).
    int          m_count;
    bit          m_last;
    int          m_after;
    bit          m_err;
    logic [31:0] m_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_last  = 1'b0;
        m_after = 0;
        m_err   = 1'b0;
        m_sum   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_check(input bit v, input logic [31:0] w, input bit l, input bit r);
        bit   loading;
        bit   running;
        bit   exp_we;
        @(negedge clk);
        in_valid = v;
        in_word  = w;
        in_last  = l;
        reset    = r;
        #2;
        loading = !m_last && !m_err;
        running = m_last && (m_after >= 1);
        exp_we  = loading && v && (m_count < 256);
        check("instr_write", 32'(instr_write), 32'(exp_we));
        check("instr_addr", instr_addr, loading ? 32'(m_count * 4) : 32'd0);
        if (exp_we) check("instr_in", instr_in, w);
        check("in_ready", 32'(in_ready), 32'(loading));
        check("word_count", 32'(word_count), 32'(m_count));
        check("done", 32'(done), 32'(running));
        check("pc_write", 32'(pc_write), 32'(running));
        check("pc_reset", 32'(pc_reset), 32'(!running));
        check("instr_read", 32'(instr_read), 32'(m_last));
        check("initializing", 32'(initializing), 32'(!m_last));
        check("error", 32'(error), 32'(m_err));
        check("cycle_no", 32'(cycle_no), running ? 32'((m_after - 1) % 65536) : 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("checksum", checksum, m_sum);
`else
        check("checksum", checksum, 32'd0);
`endif
    endtask

    task automatic commit(input bit v, input logic [31:0] w, input bit l, input bit r);
        @(posedge clk);
        if (r) begin
            model_clear();
        end else if (m_last) begin
            m_after++;
        end else if (!m_err && v) begin
            if (m_count < 256) begin
                m_count++;
                m_sum = m_sum + w;
                if (l) begin
                    m_last  = 1'b1;
                    m_after = 0;
                end
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [31:0] w, input bit l, input bit r);
        drive_check(v, w, l, r);
        commit(v, w, l, r);
    endtask

    typedef struct {
        bit          v;
        logic [31:0] w;
        bit          l;
        bit          e_we;
        logic [31:0] e_addr;
        logic [8:0]  e_cnt;
        bit          e_ready;
        bit          e_read;
        bit          e_done;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 32'h20110005, 1'b0, 1'b1, 32'd0,  9'd0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h20100002, 1'b0, 1'b1, 32'd4,  9'd1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h2012fffd, 1'b0, 1'b1, 32'd8,  9'd2, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'hac000005, 1'b0, 1'b1, 32'd12, 9'd3, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h00009820, 1'b0, 1'b1, 32'd16, 9'd4, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h00119842, 1'b0, 1'b1, 32'd20, 9'd5, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h02304822, 1'b1, 1'b1, 32'd24, 9'd6, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'd0,  9'd7, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'd0,  9'd7, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 32'hdeadbeef, 1'b1, 1'b0, 32'd0,  9'd7, 1'b0, 1'b1, 1'b1};

        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // Reset state.
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_cycle_no", 32'(cycle_no), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_initializing", 32'(initializing), 32'd1);
        check("rst_pc_reset", 32'(pc_reset), 32'd1);

        // Seven-word program from the table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v;
            in_word  = tbl[i].w;
            in_last  = tbl[i].l;
            #2;
            check("tbl_write", 32'(instr_write), 32'(tbl[i].e_we));
            check("tbl_addr", instr_addr, tbl[i].e_addr);
            if (tbl[i].e_we) check("tbl_data", instr_in, tbl[i].w);
            check("tbl_count", 32'(word_count), 32'(tbl[i].e_cnt));
            check("tbl_ready", 32'(in_ready), 32'(tbl[i].e_ready));
            check("tbl_read", 32'(instr_read), 32'(tbl[i].e_read));
            check("tbl_done", 32'(done), 32'(tbl[i].e_done));
            check("tbl_pc_reset", 32'(pc_reset), 32'(!tbl[i].e_done));
        end

        // Single word with in_last: write, one START cycle, then RUN.
        do_reset();
        drive_check(1'b1, 32'h12345678, 1'b1, 1'b0);
        check("single_write", 32'(instr_write), 32'd1);
        check("single_addr", instr_addr, 32'd0);
        commit(1'b1, 32'h12345678, 1'b1, 1'b0);
        drive_check(1'b0, 32'd0, 1'b0, 1'b0);
        check("single_start_read", 32'(instr_read), 32'd1);
        check("single_start_pcrst", 32'(pc_reset), 32'd1);
        check("single_start_done", 32'(done), 32'd0);
        commit(1'b0, 32'd0, 1'b0, 1'b0);
        drive_check(1'b0, 32'd0, 1'b0, 1'b0);
        check("single_run_done", 32'(done), 32'd1);
        check("single_run_pcrst", 32'(pc_reset), 32'd0);
        commit(1'b0, 32'd0, 1'b0, 1'b0);

        // Overflow on the 4-word instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_check(1'b1, 32'(32'hA000 + i), 1'b0, 1'b0);
            check("ovf_write", 32'(s_write), (i < 4) ? 32'd1 : 32'd0);
            commit(1'b1, 32'(32'hA000 + i), 1'b0, 1'b0);
        end
        #2;
        check("ovf_error", 32'(s_error), 32'd1);
        check("ovf_count", 32'(s_count), 32'd4);
        check("ovf_ready", 32'(s_ready), 32'd0);
        check("ovf_init", 32'(s_init), 32'd1);
        drive_check(1'b1, 32'hBBBB, 1'b1, 1'b0);
        check("ovf_hold_write", 32'(s_write), 32'd0);
        check("ovf_hold_error", 32'(s_error), 32'd1);
        check("ovf_hold_addr", s_addr, 32'd0);
        commit(1'b1, 32'hBBBB, 1'b1, 1'b0);

        // Reset mid-load (with a simultaneous word), then reload from address 0.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'(32'hC000 + i), 1'b0, 1'b0);
        step(1'b1, 32'hEEEE, 1'b1, 1'b1);
        drive_check(1'b1, 32'hD000, 1'b0, 1'b0);
        check("reload_addr0", instr_addr, 32'd0);
        commit(1'b1, 32'hD000, 1'b0, 1'b0);
        drive_check(1'b1, 32'hD001, 1'b1, 1'b0);
        check("reload_addr1", instr_addr, 32'd4);
        commit(1'b1, 32'hD001, 1'b1, 1'b0);
        #2;
        check("reload_count", 32'(word_count), 32'd2);

        // Checksum of two words wraps modulo 2^32.
        do_reset();
        step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        step(1'b1, 32'h00000002, 1'b1, 1'b0);
        #2;
`ifdef LOADER_CHECKSUM_EN
        check("checksum_wrap", checksum, 32'h00000001);
`else
        check("checksum_off", checksum, 32'h00000000);
`endif

        // Long run: cycle_no wraps, stray in_valid pulses ignored.
        do_reset();
        step(1'b1, 32'h0000CAFE, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 65537; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        #2;
        check("wrap_cycle_no", 32'(cycle_no), 32'd1);
        check("wrap_ready", 32'(in_ready), 32'd0);

        // Randomized traffic, including occasional resets.
        for (int round = 0; round < 20; round++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                step(($urandom % 3) != 0, $urandom, ($urandom % 8) == 0, ($urandom % 30) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
